// File: rtl/vscale_debug_hart_ctrl_if.sv
// Debug-module / hart-side signal bundle for vscale_debug_hart_ctrl.
// slave = the controller, master = the debug module plus the harts.
interface vscale_debug_hart_ctrl_if #(
   parameter int N_HARTS   = 1,
   parameter int HARTSEL_W = 4,
   parameter int XPR_LEN   = 32
);
   logic [HARTSEL_W-1:0]       hartsel;
   logic                       haltreq;
   logic                       resumereq;
   logic                       core_haltack;
   logic                       core_resumeack;
   logic [12:0]                register_index;
   logic                       debug_write;
   logic                       debug_read;
   logic [XPR_LEN-1:0]         debug_wdata;
   logic [XPR_LEN-1:0]         debug_rdata;
   logic                       debug_busy;
   logic                       debug_err;
   logic [N_HARTS-1:0]         hart_halt_req;
   logic [N_HARTS-1:0]         hart_resume_req;
   logic [N_HARTS-1:0]         hart_halted;
   logic [N_HARTS-1:0]         hart_reg_en;
   logic                       hart_reg_wen;
   logic [12:0]                hart_reg_idx;
   logic [XPR_LEN-1:0]         hart_reg_wdata;
   logic [N_HARTS*XPR_LEN-1:0] hart_reg_rdata;
   logic [N_HARTS-1:0]         hart_reg_ready;

   modport slave (
      input  hartsel, haltreq, resumereq,
      input  register_index, debug_write, debug_read, debug_wdata,
      input  hart_halted, hart_reg_rdata, hart_reg_ready,
      output core_haltack, core_resumeack,
      output debug_rdata, debug_busy, debug_err,
      output hart_halt_req, hart_resume_req,
      output hart_reg_en, hart_reg_wen, hart_reg_idx, hart_reg_wdata
   );

   modport master (
      output hartsel, haltreq, resumereq,
      output register_index, debug_write, debug_read, debug_wdata,
      output hart_halted, hart_reg_rdata, hart_reg_ready,
      input  core_haltack, core_resumeack,
      input  debug_rdata, debug_busy, debug_err,
      input  hart_halt_req, hart_resume_req,
      input  hart_reg_en, hart_reg_wen, hart_reg_idx, hart_reg_wdata
   );
endinterface

// File: rtl/vscale_debug_hart_ctrl.sv
// Multi-hart debug run-control and abstract register access controller.
// Optional watchdogs on HALTING/RESUMING/WAIT: define DEBUG_TIMEOUT_EN.
module vscale_debug_hart_ctrl #(
   parameter int N_HARTS        = 1,
   parameter int HARTSEL_W      = 4,
   parameter int XPR_LEN        = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                clk,
   input logic                reset_n,
   vscale_debug_hart_ctrl_if.slave dbg
);

   typedef enum logic [1:0] {
      RUNNING, HALTING, HALTED, RESUMING
   } run_e;

   typedef enum logic [1:0] {
      IDLE, REQ, WAIT
   } acc_e;

   if (N_HARTS < 1 || N_HARTS > 16 ||
       (2 ** HARTSEL_W) < N_HARTS) begin : g_bad_harts
      $error("vscale_debug_hart_ctrl: bad N_HARTS/HARTSEL_W");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("vscale_debug_hart_ctrl: TIMEOUT_CYCLES < 1");
   end

   run_e                 run_q [N_HARTS];
   logic [N_HARTS-1:0]   rack_q;
   acc_e                 acc_q;
   logic [HARTSEL_W-1:0] hart_q;
   logic                 wen_q;
   logic [12:0]          idx_q;
   logic [XPR_LEN-1:0]   wdata_q;
   logic [XPR_LEN-1:0]   rdata_q;
   logic                 haltack_q;
   logic                 resumeack_q;
   logic                 err_q;

   logic [N_HARTS-1:0]   tgt;
   logic                 sel_halted;
   logic                 sel_rack;
   logic                 lat_ready;
   logic [XPR_LEN-1:0]   lat_rdata;
   logic                 req;
   logic                 rej;
   logic [N_HARTS-1:0]   hart_to;
   logic                 acc_to;

   always_comb begin
      tgt        = '0;
      sel_halted = 1'b0;
      sel_rack   = 1'b0;
      lat_ready  = 1'b0;
      lat_rdata  = '0;
      for (int i = 0; i < N_HARTS; i++) begin
         if (dbg.hartsel == HARTSEL_W'(i)) begin
            tgt[i]     = 1'b1;
            sel_halted = (run_q[i] == HALTED);
            sel_rack   = rack_q[i];
         end
         if (hart_q == HARTSEL_W'(i)) begin
            lat_ready = dbg.hart_reg_ready[i];
            lat_rdata = dbg.hart_reg_rdata[i*XPR_LEN +: XPR_LEN];
         end
      end
   end

   assign req = dbg.debug_read | dbg.debug_write;
   assign rej = (dbg.debug_read & dbg.debug_write) | ~sel_halted |
                (dbg.register_index >= 13'h1020) | ~(|tgt);

`ifdef DEBUG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0]      hcnt_q [N_HARTS];
   logic [TW-1:0]      acnt_q;
   logic [N_HARTS-1:0] hwait;
   logic               await_c;

   // A wait state with no completion this cycle: count or expire.
   always_comb begin
      hwait   = '0;
      hart_to = '0;
      for (int i = 0; i < N_HARTS; i++) begin
         hwait[i] = (run_q[i] == HALTING && !dbg.hart_halted[i]) ||
                    (run_q[i] == RESUMING && dbg.hart_halted[i]);
         hart_to[i] = hwait[i] && (hcnt_q[i] == TLIM);
      end
      await_c = (acc_q == WAIT) && !lat_ready;
      acc_to  = await_c && (acnt_q == TLIM);
   end
`else
   assign hart_to = '0;
   assign acc_to  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N_HARTS; i++) begin
            run_q[i] <= RUNNING;
`ifdef DEBUG_TIMEOUT_EN
            hcnt_q[i] <= '0;
`endif
         end
`ifdef DEBUG_TIMEOUT_EN
         acnt_q <= '0;
`endif
         rack_q      <= '0;
         acc_q       <= IDLE;
         hart_q      <= '0;
         wen_q       <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         haltack_q   <= 1'b0;
         resumeack_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         for (int i = 0; i < N_HARTS; i++) begin
            if (dbg.resumereq && tgt[i]) rack_q[i] <= 1'b0;
            unique case (run_q[i])
               RUNNING:
                  if (dbg.haltreq && tgt[i]) run_q[i] <= HALTING;
               HALTING:
                  if (dbg.hart_halted[i]) run_q[i] <= HALTED;
                  else if (hart_to[i])    run_q[i] <= RUNNING;
               HALTED:
                  if (dbg.resumereq && tgt[i]) run_q[i] <= RESUMING;
               RESUMING:
                  if (!dbg.hart_halted[i]) begin
                     run_q[i]  <= RUNNING;
                     rack_q[i] <= 1'b1;
                  end else if (hart_to[i]) begin
                     run_q[i] <= HALTED;
                  end
               default: run_q[i] <= RUNNING;
            endcase
`ifdef DEBUG_TIMEOUT_EN
            hcnt_q[i] <= (hwait[i] && !hart_to[i]) ? hcnt_q[i] + 1'b1 : '0;
`endif
         end
`ifdef DEBUG_TIMEOUT_EN
         acnt_q <= (await_c && !acc_to) ? acnt_q + 1'b1 : '0;
`endif
         haltack_q   <= sel_halted;
         resumeack_q <= sel_rack;
         err_q <= ((acc_q == IDLE) && req && rej) | (|hart_to) | acc_to;

         unique case (acc_q)
            IDLE:
               if (req && !rej) begin
                  acc_q   <= REQ;
                  hart_q  <= dbg.hartsel;
                  wen_q   <= dbg.debug_write;
                  idx_q   <= dbg.register_index;
                  wdata_q <= dbg.debug_wdata;
               end
            REQ: acc_q <= WAIT;
            WAIT:
               if (lat_ready) begin
                  acc_q <= IDLE;
                  if (!wen_q) rdata_q <= lat_rdata;
               end else if (acc_to) begin
                  acc_q <= IDLE;
               end
            default: acc_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      dbg.hart_halt_req   = '0;
      dbg.hart_resume_req = '0;
      dbg.hart_reg_en     = '0;
      for (int i = 0; i < N_HARTS; i++) begin
         dbg.hart_halt_req[i]   = (run_q[i] == HALTING);
         dbg.hart_resume_req[i] = (run_q[i] == RESUMING);
         dbg.hart_reg_en[i] = (acc_q == REQ) && (hart_q == HARTSEL_W'(i));
      end
   end

   assign dbg.core_haltack   = haltack_q;
   assign dbg.core_resumeack = resumeack_q;
   assign dbg.debug_rdata    = rdata_q;
   assign dbg.debug_busy     = (acc_q != IDLE);
   assign dbg.debug_err      = err_q;
   assign dbg.hart_reg_wen   = wen_q;
   assign dbg.hart_reg_idx   = idx_q;
   assign dbg.hart_reg_wdata = wdata_q;

endmodule

// File: tb/tb_vscale_debug_hart_ctrl.sv
// Self-checking bench for vscale_debug_hart_ctrl with two harts.
// Run-control vector table plus directed access/reset/timeout sequences.
module tb_vscale_debug_hart_ctrl;

   localparam int NH = 2;
   localparam int HW = 4;
   localparam int XL = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [XL-1:0] r0, r1;

   vscale_debug_hart_ctrl_if #(
      .N_HARTS(NH), .HARTSEL_W(HW), .XPR_LEN(XL)
   ) dbg ();

   assign dbg.hart_reg_rdata = {r1, r0};

   vscale_debug_hart_ctrl #(
      .N_HARTS(NH), .HARTSEL_W(HW), .XPR_LEN(XL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .dbg(dbg)
   );

   typedef struct {
      logic [3:0] hs;
      logic       hr;
      logic       rs;
      logic [1:0] hh;
      logic [1:0] eh;
      logic [1:0] er;
      logic       ea;
      logic       eb;
   } vec_t;

   vec_t tv[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] hs, input logic hr, input logic rs,
                      input logic [1:0] hh, input logic [1:0] eh,
                      input logic [1:0] er, input logic ea,
                      input logic eb);
      vec_t v;
      v.hs = hs; v.hr = hr; v.rs = rs; v.hh = hh;
      v.eh = eh; v.er = er; v.ea = ea; v.eb = eb;
      tv.push_back(v);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ctl"},
          {dbg.hart_halt_req, dbg.hart_resume_req, dbg.hart_reg_en,
           dbg.core_haltack, dbg.core_resumeack, dbg.debug_busy,
           dbg.debug_err, dbg.hart_reg_wen}, 32'h0);
      chk({tag, ".rdata"}, dbg.debug_rdata, 32'h0);
      chk({tag, ".idx"}, 32'(dbg.hart_reg_idx), 32'h0);
      chk({tag, ".wdata"}, dbg.hart_reg_wdata, 32'h0);
   endtask

   task automatic err_case(input string tag, input logic [3:0] hs,
                           input logic rd, input logic wr,
                           input logic [12:0] idx);
      dbg.hartsel = hs; dbg.debug_read = rd; dbg.debug_write = wr;
      dbg.register_index = idx;
      step();
      dbg.debug_read = 1'b0; dbg.debug_write = 1'b0;
      chk({tag, ".err"}, 32'(dbg.debug_err), 32'h1);
      chk({tag, ".busy"}, 32'(dbg.debug_busy), 32'h0);
      chk({tag, ".en"}, 32'(dbg.hart_reg_en), 32'h0);
      step();
      chk({tag, ".err_pulse"}, 32'(dbg.debug_err), 32'h0);
      chk({tag, ".en2"}, 32'(dbg.hart_reg_en), 32'h0);
   endtask

   initial begin
      dbg.hartsel = '0; dbg.haltreq = 1'b0; dbg.resumereq = 1'b0;
      dbg.register_index = '0; dbg.debug_write = 1'b0;
      dbg.debug_read = 1'b0; dbg.debug_wdata = '0;
      dbg.hart_halted = '0; dbg.hart_reg_ready = '0;
      r0 = 32'hDEADBEEF; r1 = 32'h12345678;

      //  hs  hr rs hh     halt_req resume_req hack rack
      add(1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
      add(1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
      add(1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
      add(1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
      add(1, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0);
      add(1, 1, 0, 2'b10, 2'b00, 2'b00, 1, 0);
      add(1, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0);
      add(1, 0, 1, 2'b10, 2'b00, 2'b10, 1, 0);
      add(1, 0, 0, 2'b10, 2'b00, 2'b10, 0, 0);
      add(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      add(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
      add(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
      add(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      add(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
      add(3, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      add(3, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
      add(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
      add(0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
      add(0, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0);
      add(0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
      add(1, 1, 0, 2'b01, 2'b10, 2'b00, 0, 1);
      add(1, 1, 0, 2'b11, 2'b00, 2'b00, 0, 1);
      add(1, 1, 1, 2'b11, 2'b00, 2'b10, 1, 1);
      add(1, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0);
      add(1, 1, 0, 2'b01, 2'b10, 2'b00, 0, 1);
      add(1, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1);
      add(1, 0, 0, 2'b11, 2'b00, 2'b00, 1, 1);

      step(); step();
      chk_all_zero("reset");
      reset_n = 1'b1;
      step();
      chk_all_zero("reset_release");

      for (int i = 0; i < tv.size(); i++) begin
         dbg.hartsel = tv[i].hs; dbg.haltreq = tv[i].hr;
         dbg.resumereq = tv[i].rs; dbg.hart_halted = tv[i].hh;
         step();
         chk($sformatf("v%0d.halt_req", i), 32'(dbg.hart_halt_req),
             32'(tv[i].eh));
         chk($sformatf("v%0d.resume_req", i), 32'(dbg.hart_resume_req),
             32'(tv[i].er));
         chk($sformatf("v%0d.haltack", i), 32'(dbg.core_haltack),
             32'(tv[i].ea));
         chk($sformatf("v%0d.resumeack", i), 32'(dbg.core_resumeack),
             32'(tv[i].eb));
      end
      dbg.haltreq = 1'b0; dbg.resumereq = 1'b0; dbg.hart_halted = 2'b11;

      // GPR read from hart 0; wrong-hart ready and hartsel change mid-access
      dbg.hartsel = 0; dbg.debug_read = 1'b1;
      dbg.register_index = 13'h1005;
      step();
      dbg.debug_read = 1'b0;
      chk("rd.busy1", 32'(dbg.debug_busy), 32'h1);
      chk("rd.en1", 32'(dbg.hart_reg_en), 32'h1);
      chk("rd.wen", 32'(dbg.hart_reg_wen), 32'h0);
      chk("rd.idx", 32'(dbg.hart_reg_idx), 32'h1005);
      for (int k = 2; k <= 5; k++) begin
         if (k == 3) begin
            dbg.hartsel = 1; dbg.hart_reg_ready = 2'b10;
         end else begin
            dbg.hart_reg_ready = 2'b00;
         end
         step();
         chk($sformatf("rd.busy%0d", k), 32'(dbg.debug_busy), 32'h1);
         chk($sformatf("rd.en%0d", k), 32'(dbg.hart_reg_en), 32'h0);
      end
      chk("rd.rdata_hold", dbg.debug_rdata, 32'h0);
      dbg.hart_reg_ready = 2'b01;
      step();
      dbg.hart_reg_ready = 2'b00;
      chk("rd.busy_done", 32'(dbg.debug_busy), 32'h0);
      chk("rd.rdata", dbg.debug_rdata, 32'hDEADBEEF);
      chk("rd.err", 32'(dbg.debug_err), 32'h0);

      // x0 write to hart 1, request during busy is dropped
      dbg.hartsel = 1; dbg.debug_write = 1'b1;
      dbg.register_index = 13'h1000; dbg.debug_wdata = 32'hCAFEF00D;
      step();
      dbg.debug_write = 1'b0; dbg.debug_read = 1'b1;
      chk("wr.en", 32'(dbg.hart_reg_en), 32'h2);
      chk("wr.wen", 32'(dbg.hart_reg_wen), 32'h1);
      chk("wr.idx", 32'(dbg.hart_reg_idx), 32'h1000);
      chk("wr.wdata", dbg.hart_reg_wdata, 32'hCAFEF00D);
      step();
      dbg.debug_read = 1'b0; dbg.hart_reg_ready = 2'b10;
      chk("wr.busy_wait", 32'(dbg.debug_busy), 32'h1);
      chk("wr.err_drop", 32'(dbg.debug_err), 32'h0);
      step();
      dbg.hart_reg_ready = 2'b00;
      chk("wr.busy_done", 32'(dbg.debug_busy), 32'h0);
      chk("wr.rdata_kept", dbg.debug_rdata, 32'hDEADBEEF);
      step();
      chk("wr.no_err", 32'(dbg.debug_err), 32'h0);
      chk("wr.idle", 32'(dbg.debug_busy), 32'h0);

      err_case("e_idx", 0, 1'b0, 1'b1, 13'h1030);
      err_case("e_both", 0, 1'b1, 1'b1, 13'h1001);
      err_case("e_hsel", 3, 1'b1, 1'b0, 13'h1001);

      // Last GPR index is legal; CSR read from hart 1 picks its slice
      dbg.hartsel = 0; dbg.debug_write = 1'b1;
      dbg.register_index = 13'h101F;
      step();
      dbg.debug_write = 1'b0;
      chk("b1f.busy", 32'(dbg.debug_busy), 32'h1);
      chk("b1f.en", 32'(dbg.hart_reg_en), 32'h1);
      step();
      dbg.hart_reg_ready = 2'b01;
      step();
      dbg.hart_reg_ready = 2'b00;
      chk("b1f.done", 32'(dbg.debug_busy), 32'h0);
      dbg.hartsel = 1; dbg.debug_read = 1'b1;
      dbg.register_index = 13'h0300;
      step();
      dbg.debug_read = 1'b0;
      chk("csr.en", 32'(dbg.hart_reg_en), 32'h2);
      step();
      dbg.hart_reg_ready = 2'b10;
      step();
      dbg.hart_reg_ready = 2'b00;
      chk("csr.rdata", dbg.debug_rdata, 32'h12345678);

      // Reset while a halt handshake is pending
      reset_n = 1'b0;
      step();
      reset_n = 1'b1; dbg.hart_halted = 2'b00;
      dbg.hartsel = 1; dbg.haltreq = 1'b1;
      step();
      chk("rst.halting", 32'(dbg.hart_halt_req), 32'h2);
      reset_n = 1'b0;
      step();
      chk_all_zero("rst.mid");
      reset_n = 1'b1; dbg.haltreq = 1'b0;
      step();
      chk("rst.after_req", 32'(dbg.hart_halt_req), 32'h0);
      chk("rst.after_ack", 32'(dbg.core_haltack), 32'h0);
      err_case("e_run", 1, 1'b1, 1'b0, 13'h1001);

`ifdef DEBUG_TIMEOUT_EN
      begin
         int hcnt;
         int ecnt;
         dbg.hartsel = 0; dbg.haltreq = 1'b1;
         step();
         dbg.haltreq = 1'b0;
         hcnt = dbg.hart_halt_req[0] ? 1 : 0;
         ecnt = 0;
         for (int k = 0; k < 20; k++) begin
            step();
            if (dbg.hart_halt_req[0]) hcnt++;
            if (dbg.debug_err) ecnt++;
            chk($sformatf("to.hack%0d", k), 32'(dbg.core_haltack), 32'h0);
         end
         chk("to.halt_cycles", 32'(hcnt), 32'(TO));
         chk("to.err_pulses", 32'(ecnt), 32'h1);
         chk("to.halt_req_end", 32'(dbg.hart_halt_req), 32'h0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
